// File: rtl/encrypt_sched.sv
// encrypt_sched: issue controller for a fixed-latency pipelined AES-128 core.
// Round-robin issue, id tracking, credit-checked output FIFO, key-reload sequencing.
module encrypt_sched #(
    parameter int LATENCY   = 10,
    parameter int OUT_DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic [127:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [127:0] req1_data,
    output logic         req1_ready,
    output logic [127:0] core_plain_text,
    input  logic [127:0] core_cipher_text,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_id,
    input  logic         key_upd_req,
    output logic         key_load,
    output logic         key_upd_done,
    output logic         busy
);

    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + LATENCY + 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_LOAD,
        S_DONE
    } state_t;

    state_t               r_state;
    logic                 r_key_load;
    logic                 r_key_done;
    logic                 r_ptr;
    logic [127:0]         r_pt;
    logic [LATENCY-1:0]   r_vld;
    logic [LATENCY-1:0]   r_id;
    logic [127:0]         r_mem_data [OUT_DEPTH];
    logic [OUT_DEPTH-1:0] r_mem_id;
    logic [AW-1:0]        r_wp;
    logic [AW-1:0]        r_rp;
    logic [AW:0]          r_cnt;

    logic [CW-1:0]        w_inflight;
    logic [CW-1:0]        w_used;
    logic                 w_credit;
    logic                 w_gnt;
    logic                 w_can;
    logic                 w_issue;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_nempty;

    // Count valid tracking stages (blocks inside the core)
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            w_inflight = w_inflight + CW'(r_vld[i]);
        end
    end

    // Every slot already promised (queued or in flight) is charged against the FIFO
    assign w_used   = CW'(r_cnt) + w_inflight;
    assign w_credit = (w_used < CW'(OUT_DEPTH));

    // Pointer side wins when it is offering, otherwise the other side
    assign w_gnt      = (r_ptr ? req1_valid : req0_valid) ? r_ptr : ~r_ptr;
    assign w_can      = (r_state == S_RUN) && w_credit;
    assign req0_ready = w_can && !w_gnt && req0_valid;
    assign req1_ready = w_can &&  w_gnt && req1_valid;
    assign w_issue    = req0_ready | req1_ready;

    assign w_nempty = (r_cnt != '0);
    assign w_push   = r_vld[LATENCY-1];
    assign w_pop    = w_nempty && out_ready;

    assign out_valid       = w_nempty;
    assign out_data        = w_nempty ? r_mem_data[r_rp] : '0;
    assign out_id          = w_nempty ? r_mem_id[r_rp] : 1'b0;
    assign core_plain_text = r_pt;
    assign key_load        = r_key_load;
    assign key_upd_done    = r_key_done;
    assign busy            = (w_inflight != '0) || w_nempty;

    // Key-reload sequencer: drain, strobe key load, signal done, resume
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_RUN;
            r_key_load <= 1'b0;
            r_key_done <= 1'b0;
        end else begin
            r_key_load <= 1'b0;
            r_key_done <= 1'b0;
            unique case (r_state)
                S_RUN: begin
                    if (key_upd_req) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_inflight == '0) begin
                        r_state    <= S_LOAD;
                        r_key_load <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state    <= S_DONE;
                    r_key_done <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_RUN;
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    // Issue path: plaintext register, round-robin pointer, id tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pt  <= '0;
            r_ptr <= 1'b0;
            r_vld <= '0;
            r_id  <= '0;
        end else begin
            if (w_issue) begin
                r_pt  <= w_gnt ? req1_data : req0_data;
                r_ptr <= ~w_gnt;
            end
            r_vld <= {r_vld[LATENCY-2:0], w_issue};
            r_id  <= {r_id[LATENCY-2:0], w_gnt};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves count alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // FIFO storage; empty entries are never visible so no reset is needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wp] <= core_cipher_text;
            r_mem_id[r_wp]   <= r_id[LATENCY-1];
        end
    end

endmodule

// File: tb/tb_encrypt_sched.sv
// tb_encrypt_sched: random-stimulus bench with an AES-128 core model
// and an in-order reference of expected ciphertext per requester.
module tb_encrypt_sched;

    localparam int LATENCY   = 10;
    localparam int OUT_DEPTH = 16;
    localparam logic [127:0] KEY_F = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_F  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_F  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic [127:0] req0_data, req1_data;
    logic         req0_ready, req1_ready;
    logic [127:0] core_plain_text, core_cipher_text;
    logic         out_valid, out_ready, out_id;
    logic [127:0] out_data;
    logic         key_upd_req, key_load, key_upd_done, busy;

    int n_chk;
    int n_fail;

    typedef struct packed {
        logic         id;
        logic [127:0] d;
    } blk_t;

    logic [127:0] q0[$];
    logic [127:0] q1[$];
    blk_t         got_q[$];
    logic         acc_id_q[$];
    time          acc_t_q[$];

    logic [7:0]   sbox [256];
    logic [127:0] core_pipe [LATENCY-1];
    logic [127:0] core_key;
    logic [127:0] next_key;

    encrypt_sched #(.LATENCY(LATENCY), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .core_plain_text(core_plain_text), .core_cipher_text(core_cipher_text),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id),
        .key_upd_req(key_upd_req), .key_load(key_load),
        .key_upd_done(key_upd_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] aes(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] rk;
        logic [127:0] res;
        logic [7:0]   a0, a1, a2, a3;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            for (int i = 0; i < 16; i++) tmp[i] = sbox[st[i]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) st[q+4*c] = tmp[q+4*((c+q)%4)];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // AES core model: key is programmed while in reset or on key_load
    always @(posedge clk) begin
        if (reset || key_load) core_key <= next_key;
        core_pipe[0] <= aes(core_key, core_plain_text);
        for (int i = 1; i < LATENCY - 1; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_cipher_text = core_pipe[LATENCY-2];

    // Requesters: offer queue heads, never looking at ready
    always @(negedge clk) begin
        req0_valid = (q0.size() != 0);
        req0_data  = (q0.size() != 0) ? q0[0] : '0;
        req1_valid = (q1.size() != 0);
        req1_data  = (q1.size() != 0) ? q1[0] : '0;
    end

    // Handshake recorder, sampled just before the rising edge
    always @(negedge clk) begin
        #4;
        if (!reset) begin
            if (req0_valid && req0_ready) begin
                acc_id_q.push_back(1'b0);
                acc_t_q.push_back($time);
                if (q0.size() != 0) void'(q0.pop_front());
            end
            if (req1_valid && req1_ready) begin
                acc_id_q.push_back(1'b1);
                acc_t_q.push_back($time);
                if (q1.size() != 0) void'(q1.pop_front());
            end
            if (out_valid && out_ready) got_q.push_back({out_id, out_data});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        out_ready = 1'b0;
        key_upd_req = 1'b0;
        q0.delete();
        q1.delete();
        step();
        step();
        got_q.delete();
        acc_id_q.delete();
        acc_t_q.delete();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_chk++;
        if ({req0_ready, req1_ready, key_load, key_upd_done, busy, out_valid, out_id} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {req0_ready, req1_ready, key_load, key_upd_done, busy, out_valid, out_id});
        end
        n_chk++;
        if (core_plain_text !== '0) begin
            n_fail++;
            $display("FAIL reset_pt: got %h expected 0", core_plain_text);
        end
        n_chk++;
        if (out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_out_data: got %h expected 0", out_data);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        int t_acc, t_out, mid_busy;
        next_key = KEY_F;
        do_reset();
        q0.push_back(PT_F);
        t_acc = -1; t_out = -1; mid_busy = -1;
        for (int c = 1; c <= 40 && t_out < 0; c++) begin
            step();
            if (t_acc < 0 && acc_id_q.size() != 0) t_acc = c;
            if (t_acc > 0 && c == t_acc + 3) mid_busy = int'(busy);
            if (out_valid) t_out = c;
        end
        n_chk++;
        if (t_out < 0 || t_acc < 0 || t_out - t_acc != LATENCY) begin
            n_fail++;
            $display("FAIL single_latency: got acc=%0d out=%0d expected gap %0d", t_acc, t_out, LATENCY);
        end
        n_chk++;
        if (mid_busy != 1) begin
            n_fail++;
            $display("FAIL single_busy_inflight: got %0d expected 1", mid_busy);
        end
        n_chk++;
        if (out_data !== CT_F || out_id !== 1'b0) begin
            n_fail++;
            $display("FAIL single_fips: got %h id %b expected %h id 0", out_data, out_id, CT_F);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || got_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_after_pop: got busy=%b valid=%b pops=%0d expected 0 0 1",
                     busy, out_valid, got_q.size());
        end
    endtask

    task automatic test_alternate();
        logic [127:0] b0 [8];
        logic [127:0] b1 [8];
        logic [127:0] key;
        blk_t exp;
        int both_hi, bad_id, gaps;
        key = rnd128();
        next_key = key;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b0[i] = rnd128(); b1[i] = rnd128();
            q0.push_back(b0[i]); q1.push_back(b1[i]);
        end
        both_hi = 0;
        for (int c = 0; c < 100 && got_q.size() < 16; c++) begin
            step();
            if (req0_ready && req1_ready) both_hi++;
        end
        bad_id = 0; gaps = 0;
        for (int i = 0; i < acc_id_q.size(); i++) if (acc_id_q[i] != 1'(i % 2)) bad_id++;
        for (int i = 1; i < acc_t_q.size(); i++) if (acc_t_q[i] - acc_t_q[i-1] != 10) gaps++;
        n_chk++;
        if (acc_id_q.size() != 16 || bad_id != 0) begin
            n_fail++;
            $display("FAIL alt_grants: got %0d accepts %0d out of order expected 16 alternating",
                     acc_id_q.size(), bad_id);
        end
        n_chk++;
        if (gaps != 0 || both_hi != 0) begin
            n_fail++;
            $display("FAIL alt_rate: got gaps=%0d both_ready=%0d expected 0 0", gaps, both_hi);
        end
        for (int i = 0; i < 16; i++) begin
            exp = {1'(i % 2), aes(key, (i % 2 == 1) ? b1[i/2] : b0[i/2])};
            n_chk++;
            if (i >= got_q.size() || got_q[i] !== exp) begin
                n_fail++;
                $display("FAIL alt_out[%0d]: got %h expected %h", i,
                         (i < got_q.size()) ? got_q[i] : '0, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] bp [40];
        logic [127:0] key;
        int hi;
        key = rnd128();
        next_key = key;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            bp[i] = rnd128();
            q0.push_back(bp[i]);
        end
        for (int c = 0; c < 40; c++) step();
        hi = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (req0_ready) hi++;
        end
        n_chk++;
        if (acc_id_q.size() != OUT_DEPTH) begin
            n_fail++;
            $display("FAIL bp_accepts: got %0d expected %0d", acc_id_q.size(), OUT_DEPTH);
        end
        n_chk++;
        if (hi != 0 || out_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stalled: got ready_cycles=%0d valid=%b busy=%b expected 0 1 1",
                     hi, out_valid, busy);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 300 && got_q.size() < 40; c++) step();
        step();
        n_chk++;
        if (got_q.size() != 40 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d outputs busy=%b expected 40 0", got_q.size(), busy);
        end
        for (int i = 0; i < 40; i++) begin
            n_chk++;
            if (i >= got_q.size() || got_q[i] !== {1'b0, aes(key, bp[i])}) begin
                n_fail++;
                $display("FAIL bp_out[%0d]: got %h expected %h", i,
                         (i < got_q.size()) ? got_q[i] : '0, {1'b0, aes(key, bp[i])});
            end
        end
    endtask

    task automatic test_push_pop_full();
        logic [127:0] f [18];
        logic [127:0] key;
        key = rnd128();
        next_key = key;
        do_reset();
        for (int i = 0; i < 18; i++) f[i] = rnd128();
        for (int i = 0; i < 15; i++) q0.push_back(f[i]);
        for (int c = 0; c < 40 && acc_id_q.size() < 15; c++) step();
        for (int c = 0; c < 12; c++) step();
        for (int i = 15; i < 18; i++) q0.push_back(f[i]);
        for (int c = 0; c < 10 && acc_id_q.size() < 16; c++) step();
        for (int c = 0; c < LATENCY - 1; c++) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_chk++;
        if (got_q.size() != 1 || acc_id_q.size() != 16 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pp_edge: got pops=%0d accepts=%0d valid=%b expected 1 16 1",
                     got_q.size(), acc_id_q.size(), out_valid);
        end
        step();
        n_chk++;
        if (acc_id_q.size() != 17) begin
            n_fail++;
            $display("FAIL pp_credit_one: got %0d accepts expected 17", acc_id_q.size());
        end
        step();
        n_chk++;
        if (acc_id_q.size() != 17) begin
            n_fail++;
            $display("FAIL pp_credit_zero: got %0d accepts expected 17", acc_id_q.size());
        end
        out_ready = 1'b1;
        for (int c = 0; c < 100 && got_q.size() < 18; c++) step();
        for (int i = 0; i < 18; i++) begin
            n_chk++;
            if (i >= got_q.size() || got_q[i] !== {1'b0, aes(key, f[i])}) begin
                n_fail++;
                $display("FAIL pp_out[%0d]: got %h expected %h", i,
                         (i < got_q.size()) ? got_q[i] : '0, {1'b0, aes(key, f[i])});
            end
        end
    endtask

    task automatic test_key_reload();
        logic [127:0] ka, kb;
        logic [127:0] o [5];
        logic [127:0] n [4];
        blk_t exp;
        int kl_c, kd_c, nkl, nkd, got_kl, acc_kl, acc14, acc15;
        ka = rnd128(); kb = rnd128();
        next_key = ka;
        do_reset();
        next_key = kb;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            o[i] = rnd128();
            q0.push_back(o[i]);
        end
        for (int i = 0; i < 4; i++) n[i] = rnd128();
        for (int c = 0; c < 30 && acc_id_q.size() < 5; c++) step();
        key_upd_req = 1'b1;
        for (int i = 0; i < 4; i++) q1.push_back(n[i]);
        kl_c = -1; kd_c = -1; nkl = 0; nkd = 0;
        got_kl = -1; acc_kl = -1; acc14 = -1; acc15 = -1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (key_load) begin
                nkl++;
                if (kl_c < 0) begin
                    kl_c = c; got_kl = got_q.size(); acc_kl = acc_id_q.size();
                end
                key_upd_req = 1'b0;
            end
            if (key_upd_done) begin
                nkd++;
                if (kd_c < 0) kd_c = c;
            end
            if (c == 14) acc14 = acc_id_q.size();
            if (c == 15) acc15 = acc_id_q.size();
        end
        key_upd_req = 1'b0;
        n_chk++;
        if (kl_c != LATENCY + 2 || nkl != 1) begin
            n_fail++;
            $display("FAIL key_load: got cycle %0d pulses %0d expected cycle %0d pulses 1",
                     kl_c, nkl, LATENCY + 2);
        end
        n_chk++;
        if (kd_c != LATENCY + 3 || nkd != 1) begin
            n_fail++;
            $display("FAIL key_done: got cycle %0d pulses %0d expected cycle %0d pulses 1",
                     kd_c, nkd, LATENCY + 3);
        end
        n_chk++;
        if (got_kl != 6 || acc_kl != 6 || acc14 != 6) begin
            n_fail++;
            $display("FAIL key_drain: got outs=%0d accepts=%0d/%0d expected 6 6 6",
                     got_kl, acc_kl, acc14);
        end
        n_chk++;
        if (acc15 != 7) begin
            n_fail++;
            $display("FAIL key_resume: got %0d accepts expected 7", acc15);
        end
        for (int c = 0; c < 40 && got_q.size() < 9; c++) step();
        for (int i = 0; i < 9; i++) begin
            if (i < 5)       exp = {1'b0, aes(ka, o[i])};
            else if (i == 5) exp = {1'b1, aes(ka, n[0])};
            else             exp = {1'b1, aes(kb, n[i-5])};
            n_chk++;
            if (i >= got_q.size() || got_q[i] !== exp) begin
                n_fail++;
                $display("FAIL key_out[%0d]: got %h expected %h", i,
                         (i < got_q.size()) ? got_q[i] : '0, exp);
            end
        end
    endtask

    task automatic test_reset_midflight();
        int nv, nb;
        next_key = rnd128();
        do_reset();
        for (int i = 0; i < 7; i++) q0.push_back(rnd128());
        for (int c = 0; c < 20 && acc_id_q.size() < 1; c++) step();
        for (int c = 0; c < 12; c++) step();
        n_chk++;
        if (out_valid !== 1'b1 || acc_id_q.size() != 7 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: got valid=%b accepts=%0d busy=%b expected 1 7 1",
                     out_valid, acc_id_q.size(), busy);
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if ({req0_ready, req1_ready, key_load, key_upd_done, busy, out_valid, out_id} !== 7'b0
            || core_plain_text !== '0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got ctrl=%b pt=%h data=%h expected all 0",
                     {req0_ready, req1_ready, key_load, key_upd_done, busy, out_valid, out_id},
                     core_plain_text, out_data);
        end
        step();
        reset = 1'b0;
        nv = 0; nb = 0;
        for (int c = 0; c < LATENCY + 2; c++) begin
            step();
            if (out_valid) nv++;
            if (busy) nb++;
        end
        n_chk++;
        if (nv != 0 || nb != 0) begin
            n_fail++;
            $display("FAIL mid_after: got valid_cycles=%0d busy_cycles=%0d expected 0 0", nv, nb);
        end
    endtask

    initial begin
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        n_chk = 0;
        n_fail = 0;
        reset = 1'b1;
        out_ready = 1'b0;
        key_upd_req = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        next_key = KEY_F;
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_push_pop_full();
        test_key_reload();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/encrypt_sched.md
# encrypt_sched

Issue controller for the 10-round pipelined AES-128 encryption core. It arbitrates plaintext blocks from two requesters onto the core's single plaintext input and tracks each block's requester ID through the fixed-latency pipeline. Ciphertext is buffered in an output FIFO, and a credit check guarantees the non-stallable core never overruns that FIFO. It also sequences round-key reloads: it drains the pipeline, pulses the key-load strobe, then resumes.

## Interface
Parameters:
- LATENCY, 10, core cycles from plaintext presented to matching ciphertext on core_cipher_text
- OUT_DEPTH, 16, output FIFO entries; must be ≥ 2 and a power of two

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req0_valid / req1_valid  in  1  requester block offered
- req0_data / req1_data  in  128  plaintext
- req0_ready / req1_ready  out  1  block accepted this cycle when valid&ready
- core_plain_text  out  128  registered plaintext to core
- core_cipher_text  in  128  core ciphertext output
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  128  ciphertext
- out_id  out  1  requester that issued the block
- key_upd_req  in  1  level; request round-key reload
- key_load  out  1  one-cycle strobe to key-expansion logic
- key_upd_done  out  1  one-cycle pulse; reload finished
- busy  out  1  in-flight count ≠ 0 or FIFO non-empty

## Operation
- Tracking: a LATENCY-deep shift register of {valid, id}. Stage 0 loads {issue, grant_id} each cycle; otherwise it shifts every cycle with no stall. When the last stage is valid, core_cipher_text and its id are pushed to the FIFO.
- inflight: count of valid shift stages, range 0..LATENCY. credits = OUT_DEPTH − fifo_count − inflight. The block may issue only when credits ≥ 1, so a FIFO push can never find the FIFO full.
- Arbiter: round-robin with a 1-bit priority pointer, reset value 0 (req0 first).
  - Grant goes to the pointer side if its valid is high, else to the other side.
  - req_ready is driven only to the granted requester, and only when the state is RUN and credits ≥ 1.
  - After each accepted block the pointer moves to the other side.
  - ready may depend on valid. A requester must not make valid depend on ready.
- States (reset → RUN):
  - RUN: issue enabled. When key_upd_req=1, go to DRAIN; a block issued in that same cycle is still accepted.
  - DRAIN: no issue. When inflight=0, go to LOAD.
  - LOAD: key_load=1 for exactly one cycle, then go to DONE.
  - DONE: key_upd_done=1 for one cycle, then go to RUN. key_upd_req must be low by then; if it is still high, a new DRAIN cycle starts.
- FIFO: first-word-fall-through. out_data and out_id come from the head entry.
  - Pop on out_valid & out_ready.
  - A push and a pop in the same cycle are both performed; fifo_count is unchanged.
- core_plain_text: loads req_data of the granted side on issue, otherwise holds its value. It resets to 0.

## Timing
- Reset values: all *_ready=0, core_plain_text=0, out_valid=0, out_data=0, out_id=0, key_load=0, key_upd_done=0, busy=0, shift register cleared, pointer=0, FIFO empty.
- Reset asserted mid-operation: in-flight blocks and FIFO contents are discarded. Late ciphertext emerging from the core is ignored because all tracking valids are cleared.
- Block accepted at edge k: core_plain_text is updated at k, and ciphertext is pushed at edge k+LATENCY. out_valid is high after k+LATENCY if the FIFO was empty.
- Throughput is one block per cycle while credits allow. Ciphertext order equals issue order.
- With out_ready held low, exactly OUT_DEPTH blocks are accepted and then every *_ready stays 0.
- Key reload from the DRAIN entry edge: LOAD after the last in-flight push, key_load for 1 cycle, key_upd_done on the next cycle, and the first new issue is possible in the cycle after DONE.
- out_valid and out_id never glitch combinationally from req inputs; they depend only on FIFO state.

## Test plan
- Single block from req0, with AES FIPS-197 key 000102…0f and plaintext 00112233…eeff → after LATENCY cycles out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_id=0, busy drops one cycle after the pop.
- Both requesters continuously valid, with 8 distinct blocks each and out_ready=1 → grants alternate 0,1,0,1…, one issue per cycle, and outputs appear in issue order with matching ids.
- out_ready=0 with req0 always valid → exactly 16 accepts and then req0_ready stays 0. Release out_ready: 16 outputs drain, issue resumes, and no block is lost or duplicated.
- key_upd_req raised with 5 blocks in flight → no issue during DRAIN, all 5 outputs emerge, then key_load pulses once and key_upd_done pulses the next cycle. Post-reload blocks are encrypted with the new key.
- Reset asserted with 4 blocks in flight and 3 in the FIFO → all outputs are at reset values immediately, and no out_valid appears over the next LATENCY+2 cycles.
- Simultaneous FIFO push and pop at fifo_count=OUT_DEPTH−1 → count is unchanged and credits are computed correctly, with no overflow.
